// File: rtl/esp_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one ESP UART transmitter among NUM_REQ byte streams.
// Optional trailing checksum byte per packet is enabled by defining ESP_TX_CHECKSUM_EN.
module esp_uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 abort_pulse,
  output logic [15:0]          pkt_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ESP_TX_CHECKSUM_EN
    ST_CSUM = 2'd2,
`endif
    ST_SEND = 2'd1
  } state_t;

  state_t        state_r;
  logic [GW-1:0] grant_r;
  logic [GW-1:0] rr_ptr_r;
  logic [TW-1:0] timer_r;
  logic [15:0]   pkt_count_r;
`ifdef ESP_TX_CHECKSUM_EN
  logic [7:0]    csum_r;
`endif

  logic          sel_valid_s;
  logic          sel_last_s;
  logic [7:0]    sel_data_s;
  logic          found_s;
  logic [GW-1:0] pick_s;
  logic          xfer_s;
  logic          starve_s;
  logic          abort_s;
  logic [GW-1:0] next_rr_s;

  // Mux the granted source's byte stream.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_r == GW'(i)) begin
        sel_valid_s = req_valid[i];
        sel_last_s  = req_last[i];
        sel_data_s  = req_data[8*i +: 8];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Round-robin scan starting at rr_ptr_r, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    pick_s  = GW'(0);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        pick_s  = GW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign xfer_s    = (state_r == ST_SEND) && sel_valid_s && tx_ready;
  assign starve_s  = (state_r == ST_SEND) && !sel_valid_s;
  // The starved cycle that would bring the timer to TIMEOUT_CYCLES is the abort cycle.
  assign abort_s   = starve_s && (timer_r == TW'(TIMEOUT_CYCLES - 1));
  assign next_rr_s = (grant_r == GW'(NUM_REQ - 1)) ? GW'(0) : grant_r + GW'(1);

  // Output stage; everything is forced low while reset is held.
  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    req_ready   = '0;
    busy        = 1'b0;
    abort_pulse = 1'b0;
    grant_id    = GW'(0);
    pkt_count   = 16'h0000;
    if (reset) begin
      tx_valid = 1'b0;
    end else begin
      busy        = (state_r != ST_IDLE);
      abort_pulse = abort_s;
      grant_id    = grant_r;
      pkt_count   = pkt_count_r;
      case (state_r)
        ST_SEND: begin
          tx_valid = sel_valid_s;
          tx_data  = sel_data_s;
          for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = tx_ready && (grant_r == GW'(i));
          end
        end
`ifdef ESP_TX_CHECKSUM_EN
        ST_CSUM: begin
          tx_valid = 1'b1;
          tx_data  = 8'h00 - csum_r;
        end
`endif
        default: begin
          tx_valid = 1'b0;
        end
      endcase
    end
  end

  // Arbitration FSM, timeout timer, checksum accumulator and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= GW'(0);
      rr_ptr_r    <= GW'(0);
      timer_r     <= TW'(0);
      pkt_count_r <= 16'h0000;
`ifdef ESP_TX_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r <= pick_s;
            timer_r <= TW'(0);
`ifdef ESP_TX_CHECKSUM_EN
            csum_r  <= 8'h00;
`endif
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer_s) begin
            timer_r <= TW'(0);
`ifdef ESP_TX_CHECKSUM_EN
            csum_r  <= csum_r + sel_data_s;
            if (sel_last_s) begin
              state_r <= ST_CSUM;
            end
`else
            if (sel_last_s) begin
              state_r     <= ST_IDLE;
              pkt_count_r <= pkt_count_r + 16'd1;
              rr_ptr_r    <= next_rr_s;
            end
`endif
          end else if (abort_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_rr_s;
          end else if (starve_s) begin
            timer_r <= timer_r + TW'(1);
          end
        end
`ifdef ESP_TX_CHECKSUM_EN
        ST_CSUM: begin
          if (tx_ready) begin
            state_r     <= ST_IDLE;
            pkt_count_r <= pkt_count_r + 16'd1;
            rr_ptr_r    <= next_rr_s;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
